amdemod_agc: RTL
================

# amdemod_agc

Parametrised AM audio back-end for the SDR receive chain: accepts decimated baseband I/Q samples, and produces a gain-controlled PWM audio output. Detection is run-time selectable between envelope (magnitude) and coherent (I-only, carrier already removed upstream). The block removes the carrier DC with an IIR average and applies a gain that is either bus-programmed or set by an automatic gain loop. It sits after the resampler/carrier-removal stage and drives the board's audio PWM pin. A Wishbone slave is used for control.

## Interface
- IW, 12: signed input sample width.
- OW, 16: output sample / PWM width.
- GAIN_BITS, 16: unsigned gain width; unity = 2^(GAIN_BITS-2).
- SHIFT, 10: right shift (arithmetic) applied to product before saturation.
- LGALPHA, 10: log2 of carrier-average time constant.
- LGWIN, 10: log2 of AGC window length in samples.
- INITIAL_GAIN, 16'h4000: gain after reset.
- i_clk  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone strobes.
- i_wb_addr  in  2  register address.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte selects (ignored, full-word writes).
- o_wb_stall  out  1  always 0.
- o_wb_ack  out  1  ack.
- o_wb_data  out  32  read data.
- i_audio_en  in  1  PWM enable.
- i_ce  in  1  input sample valid.
- i_i, i_q  in  IW  signed baseband samples.
- o_sample_ce  out  1  output sample valid.
- o_sample  out  OW  signed audio sample.
- o_pwm_audio  out  1  PWM audio.

## Operation
- Registers: 0 gain (R/W; write loads gain, read returns live gain); 1 control: bit0 mode (0 envelope, 1 coherent), bit1 AGC hold; 2 AGC targets: [15:0] TARGET_LO, [31:16] TARGET_HI (unsigned OW-bit magnitudes, reset 16'h1000/16'h6000); 3 status read-only: [31:16] sign-extended carrier estimate, [15:0] saturation count (saturates at 16'hffff, cleared on any write to address 3).
- S1 (on i_ce): |i|, |q|; most-negative input maps to 2^(IW-1)-1.
- S2: envelope x = max + (min>>2), zero-extended to IW+1 signed; coherent x = sign-extended i.
- S3: avg += (x - avg)>>>LGALPHA (IW+1+LGALPHA-bit accumulator, reset 0); diff = x - avg_top, IW+2 signed.
- S4: prod = diff * gain (gain treated unsigned); o_sample = saturate_OW(prod>>>SHIFT); saturation increments the count.
- AGC window: counter of 2^LGWIN output samples tracks peak |o_sample|. At window end: peak > TARGET_HI -> gain -= gain>>3; peak < TARGET_LO -> gain += (gain>>6)+1; else unchanged; peak cleared. Any saturated sample -> immediate gain -= gain>>3. Gain clamped to [1, 2^GAIN_BITS-1]. Hold bit freezes gain and window counter.
- Bus write to gain overrides an AGC update in the same cycle and restarts the window.
- PWM: free-running OW-bit counter, bit-reversed, compared < offset-binary o_sample (MSB inverted), registered. i_audio_en low -> o_pwm_audio toggles every clock.

## Timing
- Reset: o_wb_ack 0, o_wb_data 0, o_sample_ce 0, o_sample 0, o_pwm_audio 0, gain INITIAL_GAIN, mode 0, hold 0, avg 0, counters 0.
- o_sample_ce asserted exactly 4 cycles after i_ce, one-cycle pulse; i_ce may be asserted every cycle (fully pipelined).
- o_wb_ack = i_wb_stb one cycle later; o_wb_data valid with ack.
- Gain change takes effect on the next S4 sample after update.
- Mode change mid-stream: samples already in the pipeline complete in old mode.
- Reset mid-operation: pipeline valids clear immediately; no o_sample_ce after deassertion until a new i_ce.

## Configuration
- AMDEMOD_AGC_EN defined: AGC window, peak tracker, and saturation attack are built; hold bit and register 2 are active.
- Undefined: gain changes only via bus writes; register 2 reads 0, writes ignored; hold bit reads 0; saturation count still maintained.

## Test plan
- Coherent mode, gain 16'h4000, avg forced 0 by reset, single i_ce with i=100 -> o_sample = 1600 four cycles later.
- Envelope, i=-2048, q=400 -> x = 2047+100 = 2147 at S2.
- Coherent, i=2047, gain 16'hffff -> o_sample = 32767, saturation count 1, AGC build: gain drops to 16'hffff - 16'h1fff.
- AGC build, constant small input yielding peak 100 over 1024 samples from gain 16'h4000 -> gain 16'h4101 at window end.
- Write gain register same cycle as window end -> written value retained, window restarts.
- i_audio_en low -> o_pwm_audio toggles every cycle; reset asserted mid-pipeline -> o_sample_ce stays 0.

Source files
------------

// File: rtl/amdemod_agc.sv
// amdemod_agc: AM audio back-end with carrier-DC removal, gain and PWM output.
//
// Decimated baseband I/Q samples pass through a four-stage pipeline:
//   S1 |i|,|q|          S2 detector (envelope or coherent)
//   S3 carrier removal  S4 gain, arithmetic shift and saturation
// The audio sample then drives a bit-reversed-counter PWM on o_pwm_audio.
// A Wishbone slave exposes gain, control, AGC targets and status.
//
// Build option: define AMDEMOD_AGC_EN to build the automatic gain loop
// (window peak tracker, saturation attack, hold bit, target register).
// Without it the gain only changes through bus writes.
//
// Ports
//   i_clk, i_reset             clock, asynchronous active-high reset
//   i_wb_cyc/stb/we/addr/data  Wishbone slave request (i_wb_sel ignored)
//   o_wb_stall/ack/data        Wishbone slave response
//   i_audio_en                 PWM enable (low: o_pwm_audio toggles)
//   i_ce, i_i, i_q             input sample valid and signed I/Q
//   o_sample_ce, o_sample      output sample valid and signed audio
//   o_pwm_audio                PWM audio pin
module amdemod_agc #(
  parameter int IW        = 12,
  parameter int OW        = 16,
  parameter int GAIN_BITS = 16,
  parameter int SHIFT     = 10,
  parameter int LGALPHA   = 10,
  parameter int LGWIN     = 10,
  parameter logic [GAIN_BITS-1:0] INITIAL_GAIN = 16'h4000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [1:0]           i_wb_addr,
  input  logic [31:0]          i_wb_data,
  input  logic [3:0]           i_wb_sel,
  output logic                 o_wb_stall,
  output logic                 o_wb_ack,
  output logic [31:0]          o_wb_data,
  input  logic                 i_audio_en,
  input  logic                 i_ce,
  input  logic signed [IW-1:0] i_i,
  input  logic signed [IW-1:0] i_q,
  output logic                 o_sample_ce,
  output logic signed [OW-1:0] o_sample,
  output logic                 o_pwm_audio
);

  localparam int AW = IW + 1 + LGALPHA;
  localparam int PW = IW + GAIN_BITS + 3;

  logic unused_bits;
  assign unused_bits = &{1'b0, i_wb_sel, i_wb_data};
  assign o_wb_stall  = 1'b0;

  logic                 wb_wr;
  logic [GAIN_BITS-1:0] gain;
  logic                 mode;
  logic                 hold;
  logic [15:0]          sat_cnt;
  logic                 sat_r;

  assign wb_wr = i_wb_cyc & i_wb_stb & i_wb_we;

  // ---------------- S1: magnitudes ----------------
  logic [IW-2:0] neg_i, neg_q, abs_i, abs_q;
  logic          ce1, s1_mode;
  logic [IW-2:0] s1_abs_i, s1_abs_q;
  logic [IW-1:0] s1_i;

  // The most negative input has no positive twin; it maps to full scale.
  always_comb begin
    neg_i = (~i_i[IW-2:0]) + 1'b1;
    neg_q = (~i_q[IW-2:0]) + 1'b1;
    abs_i = i_i[IW-2:0];
    abs_q = i_q[IW-2:0];
    if (i_i[IW-1]) abs_i = (i_i[IW-2:0] == '0) ? '1 : neg_i;
    if (i_q[IW-1]) abs_q = (i_q[IW-2:0] == '0) ? '1 : neg_q;
  end

  // Mode is captured with the sample so in-flight samples keep their mode.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ce1      <= 1'b0;
      s1_mode  <= 1'b0;
      s1_abs_i <= '0;
      s1_abs_q <= '0;
      s1_i     <= '0;
    end else begin
      ce1 <= i_ce;
      if (i_ce) begin
        s1_mode  <= mode;
        s1_abs_i <= abs_i;
        s1_abs_q <= abs_q;
        s1_i     <= i_i;
      end
    end
  end

  // ---------------- S2: detector ----------------
  logic [IW-2:0]      mx, mn;
  logic signed [IW:0] x_c, s2_x;
  logic               ce2;

  always_comb begin
    mx = (s1_abs_i > s1_abs_q) ? s1_abs_i : s1_abs_q;
    mn = (s1_abs_i > s1_abs_q) ? s1_abs_q : s1_abs_i;
    if (s1_mode) x_c = {s1_i[IW-1], s1_i};
    else         x_c = {2'b00, mx} + {2'b00, mn >> 2};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ce2  <= 1'b0;
      s2_x <= '0;
    end else begin
      ce2 <= ce1;
      if (ce1) s2_x <= x_c;
    end
  end

  // ---------------- S3: carrier average removal ----------------
  // acc holds avg scaled by 2^LGALPHA; adding (x - avg) to it moves the
  // unscaled average by (x - avg)/2^LGALPHA.
  logic signed [AW-1:0] acc;
  logic signed [IW:0]   avg_top;
  logic signed [IW+1:0] diff_c, s3_diff;
  logic                 ce3;

  always_comb begin
    avg_top = acc[AW-1:LGALPHA];
    diff_c  = {s2_x[IW], s2_x} - {avg_top[IW], avg_top};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ce3     <= 1'b0;
      acc     <= '0;
      s3_diff <= '0;
    end else begin
      ce3 <= ce2;
      if (ce2) begin
        s3_diff <= diff_c;
        acc     <= acc + {{(LGALPHA-1){diff_c[IW+1]}}, diff_c};
      end
    end
  end

  // ---------------- S4: gain, shift, saturate ----------------
  logic signed [PW-1:0] prod, shifted;
  logic                 sat_hi, sat_lo;

  always_comb begin
    prod    = PW'(s3_diff) * PW'($signed({1'b0, gain}));
    shifted = prod >>> SHIFT;
    sat_hi  = ~shifted[PW-1] & (|shifted[PW-2:OW-1]);
    sat_lo  = shifted[PW-1] & ~(&shifted[PW-2:OW-1]);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_sample_ce <= 1'b0;
      o_sample    <= '0;
      sat_r       <= 1'b0;
    end else begin
      o_sample_ce <= ce3;
      sat_r       <= ce3 & (sat_hi | sat_lo);
      if (ce3) begin
        if (sat_hi)      o_sample <= {1'b0, {(OW-1){1'b1}}};
        else if (sat_lo) o_sample <= {1'b1, {(OW-1){1'b0}}};
        else             o_sample <= shifted[OW-1:0];
      end
    end
  end

  // ---------------- saturation counter ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      sat_cnt <= '0;
    else if (wb_wr && i_wb_addr == 2'd3)
      sat_cnt <= '0;
    else if (o_sample_ce && sat_r && sat_cnt != '1)
      sat_cnt <= sat_cnt + 1'b1;
  end

  // ---------------- control, gain and AGC ----------------
`ifdef AMDEMOD_AGC_EN
  logic [OW-1:0]        target_lo, target_hi;
  logic [LGWIN-1:0]     win_cnt;
  logic [OW-1:0]        peak, abs_out, peak_now;
  logic                 win_end;
  logic [GAIN_BITS-1:0] dn, gain_dn, gain_up;
  logic [GAIN_BITS:0]   up;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode      <= 1'b0;
      hold      <= 1'b0;
      target_lo <= OW'(16'h1000);
      target_hi <= OW'(16'h6000);
    end else if (wb_wr) begin
      if (i_wb_addr == 2'd1) begin
        mode <= i_wb_data[0];
        hold <= i_wb_data[1];
      end
      if (i_wb_addr == 2'd2) begin
        target_lo <= OW'(i_wb_data[15:0]);
        target_hi <= OW'(i_wb_data[31:16]);
      end
    end
  end

  always_comb begin
    abs_out  = o_sample[OW-1] ? -o_sample : o_sample;
    peak_now = (abs_out > peak) ? abs_out : peak;
    win_end  = (win_cnt == '1);
    dn       = gain - (gain >> 3);
    gain_dn  = (dn == '0) ? {{(GAIN_BITS-1){1'b0}}, 1'b1} : dn;
    up       = {1'b0, gain} + {1'b0, gain >> 6} + 1'b1;
    gain_up  = up[GAIN_BITS] ? '1 : up[GAIN_BITS-1:0];
  end

  // A bus write to the gain wins over any AGC decision in the same cycle
  // and starts a fresh window.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gain    <= INITIAL_GAIN;
      win_cnt <= '0;
      peak    <= '0;
    end else if (wb_wr && i_wb_addr == 2'd0) begin
      gain    <= i_wb_data[GAIN_BITS-1:0];
      win_cnt <= '0;
      peak    <= '0;
    end else if (o_sample_ce && !hold) begin
      win_cnt <= win_cnt + 1'b1;
      peak    <= win_end ? '0 : peak_now;
      if (sat_r)
        gain <= gain_dn;
      else if (win_end) begin
        if (peak_now > target_hi)      gain <= gain_dn;
        else if (peak_now < target_lo) gain <= gain_up;
      end
    end
  end
`else
  assign hold = 1'b0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      mode <= 1'b0;
    else if (wb_wr && i_wb_addr == 2'd1)
      mode <= i_wb_data[0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      gain <= INITIAL_GAIN;
    else if (wb_wr && i_wb_addr == 2'd0)
      gain <= i_wb_data[GAIN_BITS-1:0];
  end
`endif

  // ---------------- Wishbone read ----------------
  logic [31:0] rd_data;
  logic [15:0] est;

  always_comb begin
    est     = {{(16-IW-1){avg_top[IW]}}, avg_top};
    rd_data = '0;
    case (i_wb_addr)
      2'd0:    rd_data = 32'(gain);
      2'd1:    rd_data = {30'b0, hold, mode};
`ifdef AMDEMOD_AGC_EN
      2'd2:    rd_data = {16'(target_hi), 16'(target_lo)};
`else
      2'd2:    rd_data = '0;
`endif
      default: rd_data = {est, sat_cnt};
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= i_wb_stb;
      if (i_wb_stb) o_wb_data <= rd_data;
    end
  end

  // ---------------- PWM ----------------
  // Bit-reversing the counter spreads the on-time across the period,
  // pushing the PWM energy well above the audio band.
  logic [OW-1:0] pwm_cnt, pwm_rev, pwm_level;

  always_comb begin
    pwm_rev = '0;
    for (int unsigned b = 0; b < OW; b++)
      pwm_rev[b] = pwm_cnt[OW-1-b];
    pwm_level = {~o_sample[OW-1], o_sample[OW-2:0]};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pwm_cnt     <= '0;
      o_pwm_audio <= 1'b0;
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      o_pwm_audio <= i_audio_en ? (pwm_rev < pwm_level) : ~o_pwm_audio;
    end
  end

endmodule
